// File: rtl/imm_materializer_pkg.sv
// Shared opcode constants, value classes and FSM states for the immediate materializer.
// No logic of its own beyond an I-type word packing helper.
package imm_materializer_pkg;

  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  typedef enum logic [1:0] {
    SEXT = 2'd0,
    ZEXT = 2'd1,
    HIGH = 2'd2,
    FULL = 2'd3
  } imm_cls_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT1 = 2'd1,
    EMIT2 = 2'd2
  } mat_state_e;

  function automatic logic [31:0] itype(input logic [5:0]  op,
                                        input logic [4:0]  rs,
                                        input logic [4:0]  rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/imm_materializer_classify.sv
// Combinational classifier picking the shortest instruction sequence for a 32-bit constant.
// Zero latency, no flow control.
module imm_classify
  import imm_materializer_pkg::*;
(
  input  logic [31:0] value,
  output imm_cls_e    imm_cls
);

  logic sext_fit;
  logic zext_fit;
  logic high_fit;

  // value[31:15] all equal means a 16-bit sign-extended immediate reproduces it
  assign sext_fit = (value[31:15] == 17'h00000) || (value[31:15] == 17'h1FFFF);
  assign zext_fit = (value[31:16] == 16'h0000);
  assign high_fit = (value[15:0]  == 16'h0000);

  always_comb begin
    imm_cls = FULL;
    if (sext_fit) begin
      imm_cls = SEXT;
    end else if (zext_fit) begin
      imm_cls = ZEXT;
    end else if (high_fit) begin
      imm_cls = HIGH;
    end
  end

endmodule

// File: rtl/imm_materializer.sv
// Turns a 32-bit constant into one or two MIPS I-type words (ADDIU/ORI/LUI[+ORI]).
// First word valid the cycle after acceptance; words held while out_ready is low, in_ready low until idle.
module imm_materializer
  import imm_materializer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  input  logic [4:0]  in_rt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_last,
  output logic        out_lui_op,
  output logic        out_signed_op
);

  mat_state_e  state_q, state_d;
  imm_cls_e    cls_q, cls_d;
  logic [15:0] lo16_q, lo16_d;
  logic [4:0]  rt_q, rt_d;
  logic [31:0] instr_q, instr_d;
  logic        last_q, last_d;
  logic        lui_q, lui_d;
  logic        sgn_q, sgn_d;
  imm_cls_e    in_cls;

  imm_classify u_classify (
    .value   (in_value),
    .imm_cls (in_cls)
  );

  assign in_ready      = (state_q == IDLE);
  assign out_valid     = (state_q != IDLE);
  assign out_instr     = instr_q;
  assign out_last      = last_q;
  assign out_lui_op    = lui_q;
  assign out_signed_op = sgn_q;

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    lo16_d  = lo16_q;
    rt_d    = rt_q;
    instr_d = instr_q;
    last_d  = last_q;
    lui_d   = lui_q;
    sgn_d   = sgn_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT1;
          cls_d   = in_cls;
          lo16_d  = in_value[15:0];
          rt_d    = in_rt;
          case (in_cls)
            SEXT: begin
              instr_d = itype(OP_ADDIU, 5'd0, in_rt, in_value[15:0]);
              last_d  = 1'b1;
              lui_d   = 1'b0;
              sgn_d   = 1'b1;
            end
            ZEXT: begin
              instr_d = itype(OP_ORI, 5'd0, in_rt, in_value[15:0]);
              last_d  = 1'b1;
              lui_d   = 1'b0;
              sgn_d   = 1'b0;
            end
            default: begin
              // HIGH ends here; FULL still owes the ORI of the low half
              instr_d = itype(OP_LUI, 5'd0, in_rt, in_value[31:16]);
              last_d  = (in_cls == HIGH);
              lui_d   = 1'b1;
              sgn_d   = 1'b0;
            end
          endcase
        end
      end
      EMIT1: begin
        if (out_ready) begin
          if (cls_q == FULL) begin
            state_d = EMIT2;
            instr_d = itype(OP_ORI, rt_q, rt_q, lo16_q);
            last_d  = 1'b1;
            lui_d   = 1'b0;
            sgn_d   = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      EMIT2: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cls_q   <= SEXT;
      lo16_q  <= 16'h0000;
      rt_q    <= 5'd0;
      instr_q <= 32'h0000_0000;
      last_q  <= 1'b0;
      lui_q   <= 1'b0;
      sgn_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      lo16_q  <= lo16_d;
      rt_q    <= rt_d;
      instr_q <= instr_d;
      last_q  <= last_d;
      lui_q   <= lui_d;
      sgn_q   <= sgn_d;
    end
  end

endmodule

// File: doc/imm_materializer.md
IMM_MATERIALIZER -- requirements
Module: imm_materializer

Interface
REQ-001 SHALL have parameters: none; all opcodes are fixed constants (see Structure).
REQ-002 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_valid  input  1  request carries a 32-bit constant to load.
REQ-005 SHALL have port: in_ready  output  1  request accepted when in_valid & in_ready.
REQ-006 SHALL have port: in_value  input  32  constant to materialize.
REQ-007 SHALL have port: in_rt  input  5  destination register number.
REQ-008 SHALL have port: out_valid  output  1  out_instr holds a valid instruction word.
REQ-009 SHALL have port: out_ready  input  1  consumer takes word when out_valid & out_ready.
REQ-010 SHALL have port: out_instr  output  32  I-type word {op[31:26], rs[25:21], rt[20:16], imm[15:0]}.
REQ-011 SHALL have port: out_last  output  1  current word is the final word of the sequence.
REQ-012 SHALL have port: out_lui_op  output  1  decode hint; 1 when out_instr is LUI.
REQ-013 SHALL have port: out_signed_op  output  1  decode hint; 1 when out_instr imm is sign-extended (ADDIU).

Function
REQ-014 SHALL classify each accepted value, first match wins: SEXT (value[31:15] all equal) -> ADDIU rt,$0,value[15:0]; ZEXT (value[31:16]==0) -> ORI rt,$0,value[15:0]; HIGH (value[15:0]==0) -> LUI rt,value[31:16]; FULL otherwise -> LUI rt,value[31:16] then ORI rt,rt,value[15:0].
REQ-015 SHALL use FSM states IDLE, EMIT1, EMIT2.
REQ-016 IDLE: in_ready=1, out_valid=0; on acceptance latch value/rt/class, go to EMIT1.
REQ-017 EMIT1: out_valid=1 with first word; out_last=1 unless class FULL; on out_ready go to EMIT2 if FULL else IDLE.
REQ-018 EMIT2: out_valid=1 with ORI rt,rt,low16, out_last=1; on out_ready go to IDLE.
REQ-019 SHALL hold out_instr, out_last, hints stable while out_valid=1 and out_ready=0.
REQ-020 in_ready SHALL be 0 in EMIT1/EMIT2; new requests are not accepted until IDLE (no overlap).
REQ-021 Latency: first word valid the cycle after acceptance; throughput 1 word/cycle under out_ready=1.
REQ-022 out_instr, out_last, out_lui_op, out_signed_op SHALL be registered outputs; out_valid/in_ready decode from state only.
REQ-023 rt=0 SHALL be processed normally (no suppression).
REQ-024 out_lui_op=1 only for LUI words; out_signed_op=1 only for ADDIU words; both 0 for ORI.

Reset
REQ-025 Reset asserted at any time (including mid-sequence) SHALL force IDLE, discard the pending sequence, and set in_ready=1, out_valid=0, out_instr=0, out_last=0, out_lui_op=0, out_signed_op=0.
REQ-026 First acceptance after reset deassertion SHALL be possible on the first rising edge with reset low.

Structure
REQ-027 Shared package SHALL hold opcode constants OP_ADDIU=6'h09, OP_ORI=6'h0D, OP_LUI=6'h0F, class enum {SEXT, ZEXT, HIGH, FULL}, and FSM state enum.
REQ-028 One combinational sub-module imm_classify (in: value[31:0]; out: class) SHALL be used; FSM and output registers live in imm_materializer.

Verification
REQ-029 value=0x00001234, rt=8, out_ready=1 -> one word 0x24081234 (ADDIU), out_last=1, out_signed_op=1, valid the cycle after acceptance.
REQ-030 value=0x0000FFFF, rt=9 -> one word 0x3409FFFF (ORI), out_last=1; value=0xFFFF8000, rt=9 -> 0x24098000 (ADDIU).
REQ-031 value=0x12340000, rt=10 -> one word 0x3C0A1234 (LUI), out_lui_op=1, out_last=1; value=0xFFFF0000 -> LUI imm 0xFFFF.
REQ-032 value=0x12345678, rt=10, out_ready held 0 for 3 cycles -> 0x3C0A1234 held stable with out_last=0, then 0x354A5678 with out_last=1; in_ready=0 throughout.
REQ-033 Reset asserted while in EMIT2 -> next cycle out_valid=0, in_ready=1, all outputs 0; subsequent value=0 accepted -> 0x24080000 for rt=8.
REQ-034 Back-to-back requests with in_valid held 1 -> second accepted only after IDLE re-entered; no word lost or duplicated.
